cdc_hs_arbiter: RTL and testbench

- Source-side controller for a shared 4-phase req/ack crossing channel to another clock domain.
- Round-robin arbitrates NUM_REQ requesters onto one data word plus requester id.
- Drives the level req and holds data stable for the full handshake.
- Consumes the far-side ack, which has already passed through the 2-flop level synchronizer in this domain, and aborts hung transfers with a timeout.

---
 rtl/cdc_hs_arbiter.sv | 141 ++++++++++++++
 tb/tb_cdc_hs_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_hs_arbiter.sv
// Source-side controller for a shared 4-phase req/ack channel into another clock domain.
// Round-robin arbitrates NUM_REQ requesters, latches the winning word and id, holds them
// stable for the full handshake and aborts transfers whose ack never arrives.
module cdc_hs_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      xfer_req,
  output logic [DATA_W-1:0]         xfer_data,
  output logic [ID_W-1:0]           xfer_id,
  input  logic                      xfer_ack,
  output logic                      busy,
  output logic                      timeout_err
);

  typedef enum logic [1:0] {StIdle, StReq, StRel} state_e;

  localparam bit              ToEn   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] ToLast = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                xfer_req_q, xfer_req_d;
  logic [DATA_W-1:0]   xfer_data_q, xfer_data_d;
  logic [ID_W-1:0]     xfer_id_q, xfer_id_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic                busy_q, busy_d;
  logic                timeout_err_q, timeout_err_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;

  logic [ID_W-1:0]     grant;
  logic                grant_vld;
  int unsigned         idx;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant     = last_grant_q;
    grant_vld = 1'b0;
    idx       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_grant_q) + i) % NUM_REQ;
      if (!grant_vld && req_valid[idx]) begin
        grant     = ID_W'(idx);
        grant_vld = 1'b1;
      end
    end
  end

  // Handshake FSM next-state; every output is computed here and registered below.
  always_comb begin
    state_d       = state_q;
    xfer_req_d    = xfer_req_q;
    xfer_data_d   = xfer_data_q;
    xfer_id_d     = xfer_id_q;
    last_grant_d  = last_grant_q;
    req_ready_d   = '0;
    busy_d        = busy_q;
    timeout_err_d = 1'b0;
    cnt_d         = cnt_q;
    unique case (state_q)
      StIdle: begin
        // A stale ack from the previous handshake must fall before a new req may rise.
        if (grant_vld && !xfer_ack) begin
          xfer_data_d  = req_data[32'(grant)*DATA_W +: DATA_W];
          xfer_id_d    = grant;
          last_grant_d = grant;
          xfer_req_d   = 1'b1;
          busy_d       = 1'b1;
          cnt_d        = '0;
          state_d      = StReq;
        end
      end
      StReq: begin
        cnt_d = cnt_q + 1'b1;
        // Ack takes priority over a timeout landing on the same cycle.
        if (xfer_ack) begin
          xfer_req_d  = 1'b0;
          req_ready_d = NUM_REQ'(1) << xfer_id_q;
          state_d     = StRel;
        end else if (ToEn && (cnt_q == ToLast)) begin
          xfer_req_d    = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = StRel;
        end
      end
      StRel: begin
        xfer_req_d = 1'b0;
        if (!xfer_ack) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        xfer_req_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      xfer_req_q    <= 1'b0;
      xfer_data_q   <= '0;
      xfer_id_q     <= '0;
      last_grant_q  <= ID_W'(NUM_REQ - 1);
      req_ready_q   <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      xfer_req_q    <= xfer_req_d;
      xfer_data_q   <= xfer_data_d;
      xfer_id_q     <= xfer_id_d;
      last_grant_q  <= last_grant_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign xfer_req    = xfer_req_q;
  assign xfer_data   = xfer_data_q;
  assign xfer_id     = xfer_id_q;
  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// Scoreboard bench for cdc_hs_arbiter: stimulus pushes expected events (grant start,
// req_ready pulse, timeout pulse); an independent monitor pops and compares them.
module tb_cdc_hs_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int IW = 2;
  localparam int TO = 8;
  localparam int TW = 8;

  localparam int KStart = 0;
  localparam int KReady = 1;
  localparam int KTo    = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              xfer_req;
  logic [DW-1:0]     xfer_data;
  logic [IW-1:0]     xfer_id;
  logic              xfer_ack;
  logic              busy;
  logic              timeout_err;

  cdc_hs_arbiter #(
    .NUM_REQ(NR),
    .DATA_W (DW),
    .ID_W   (IW),
    .TIMEOUT(TO),
    .TO_W   (TW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .xfer_req   (xfer_req),
    .xfer_data  (xfer_data),
    .xfer_id    (xfer_id),
    .xfer_ack   (xfer_ack),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          id;
    logic [15:0] data;
  } ev_t;

  ev_t  exp_q[$];
  int   tests = 0;
  int   fails = 0;
  logic drop_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
    end
  endtask

  task automatic push(input int k, input int id, input logic [15:0] d);
    ev_t e;
    e.kind = k;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int k, input int id, input logic [15:0] d);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind=%0d id=%0h data=%0h, required no event", k, id, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.id != id || e.data !== d) begin
        fails++;
        $display("FAIL event: got kind=%0d id=%0h data=%0h, required kind=%0d id=%0h data=%0h",
                 k, id, d, e.kind, e.id, e.data);
      end
    end
  endtask

  // Monitor: sample outputs mid-cycle and match every observable event against the queue.
  logic          req_p  = 1'b0;
  logic          busy_p = 1'b0;
  logic [DW-1:0] data_p = '0;
  logic [IW-1:0] id_p   = '0;
  always @(negedge clk) begin
    if (req_ready != 0) begin
      pop_cmp(KReady, int'(req_ready), 16'h0);
      check("ready_on_req_fall", {30'b0, req_p, xfer_req}, 32'h2);
    end
    if (timeout_err === 1'b1) pop_cmp(KTo, 0, 16'h0);
    if (xfer_req === 1'b1 && req_p === 1'b0) pop_cmp(KStart, int'(xfer_id), xfer_data);
    if (busy_p === 1'b1 && busy === 1'b1) begin
      check("stable_data", 32'(xfer_data), 32'(data_p));
      check("stable_id", 32'(xfer_id), 32'(id_p));
    end
    req_p  <= xfer_req;
    busy_p <= busy;
    data_p <= xfer_data;
    id_p   <= xfer_id;
  end

  // Requesters release req_valid after their ready pulse when drop_en is set.
  task automatic tick();
    @(negedge clk);
    if (drop_en) req_valid = req_valid & ~req_ready;
  endtask

  task automatic set_data(input int i, input logic [15:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  task automatic wait_req(input logic lvl, input string name);
    int n = 0;
    while (xfer_req !== lvl && n < 100) begin
      tick();
      n++;
    end
    check(name, 32'(xfer_req), 32'(lvl));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 32'h0);
  endtask

  // Far-side model: ack follows req rise and fall each after d cycles.
  task automatic handshake(input int d);
    wait_req(1'b1, "hs_req_rise");
    repeat (d) tick();
    xfer_ack = 1'b1;
    wait_req(1'b0, "hs_req_fall");
    repeat (d) tick();
    xfer_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    xfer_ack  = 1'b0;
    req_valid = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drained(input string name);
    check(name, 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    xfer_ack  = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (3) tick();
    check("rst_xfer_req", 32'(xfer_req), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_xfer_id", 32'(xfer_id), 32'h0);
    check("rst_xfer_data", 32'(xfer_data), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_timeout_err", 32'(timeout_err), 32'h0);
    reset = 1'b0;

    // 1: single transfer from requester 2.
    for (int i = 0; i < NR; i++) set_data(i, 16'h1111 * 16'(i + 1));
    set_data(2, 16'hBEEF);
    push(KStart, 2, 16'hBEEF);
    push(KReady, 4, 16'h0);
    req_valid = 4'b0100;
    handshake(3);
    wait_idle("t1_busy_low");
    drained("t1_drained");

    // 2: all valid continuously, grants rotate 0,1,2,3,0.
    do_reset();
    drop_en = 1'b0;
    for (int i = 0; i < NR; i++) set_data(i, 16'h1000 + 16'(i));
    for (int i = 0; i < 5; i++) begin
      push(KStart, i % NR, 16'h1000 + 16'(i % NR));
      push(KReady, 1 << (i % NR), 16'h0);
    end
    req_valid = 4'b1111;
    repeat (5) handshake(3);
    req_valid = '0;
    drop_en   = 1'b1;
    wait_idle("t2_busy_low");
    drained("t2_drained");

    // 3: no ack, timeout after 8 cycles; next grant to the other valid requester.
    do_reset();
    set_data(0, 16'hA000);
    set_data(2, 16'hA002);
    push(KStart, 0, 16'hA000);
    push(KTo, 0, 16'h0);
    push(KStart, 2, 16'hA002);
    push(KReady, 4, 16'h0);
    req_valid = 4'b0101;
    wait_req(1'b1, "t3_req_rise");
    begin
      int n = 0;
      while (xfer_req === 1'b1 && n < 50) begin
        tick();
        n++;
      end
      check("t3_req_high_cycles", 32'(n), 32'd8);
    end
    handshake(3);
    req_valid = '0;
    wait_idle("t3_busy_low");
    drained("t3_drained");

    // 4: stale ack holds off the grant until it falls.
    do_reset();
    set_data(0, 16'h4444);
    push(KStart, 0, 16'h4444);
    push(KReady, 1, 16'h0);
    xfer_ack  = 1'b1;
    req_valid = 4'b0001;
    repeat (5) tick();
    check("t4_no_req_with_ack", 32'(xfer_req), 32'h0);
    check("t4_idle_with_ack", 32'(busy), 32'h0);
    xfer_ack = 1'b0;
    tick();
    check("t4_req_after_ack_fall", 32'(xfer_req), 32'h1);
    handshake(3);
    wait_idle("t4_busy_low");
    drained("t4_drained");

    // 5: reset during REQ; afterwards requester 0 wins over 1 again.
    do_reset();
    set_data(0, 16'h5550);
    set_data(1, 16'h5551);
    push(KStart, 0, 16'h5550);
    req_valid = 4'b0001;
    wait_req(1'b1, "t5_req_rise");
    tick();
    tick();
    reset     = 1'b1;
    req_valid = 4'b0011;
    tick();
    check("t5_rst_xfer_req", 32'(xfer_req), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_req_ready", 32'(req_ready), 32'h0);
    check("t5_rst_timeout_err", 32'(timeout_err), 32'h0);
    tick();
    reset = 1'b0;
    push(KStart, 0, 16'h5550);
    push(KReady, 1, 16'h0);
    push(KStart, 1, 16'h5551);
    push(KReady, 2, 16'h0);
    handshake(3);
    handshake(3);
    req_valid = '0;
    wait_idle("t5_busy_low");
    drained("t5_drained");

    // 6: valid dropped after grant; ack lands on the last timeout cycle and wins.
    do_reset();
    set_data(2, 16'h6666);
    push(KStart, 2, 16'h6666);
    push(KReady, 4, 16'h0);
    req_valid = 4'b0100;
    wait_req(1'b1, "t6_req_rise");
    tick();
    req_valid = '0;
    repeat (6) tick();
    xfer_ack = 1'b1;
    wait_req(1'b0, "t6_req_fall");
    repeat (3) tick();
    xfer_ack = 1'b0;
    wait_idle("t6_busy_low");
    repeat (3) tick();
    drained("t6_drained");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
